// File: rtl/multiple_add_serializer.sv
// Captures a NUM_ADDERS-word result vector on valid/ready and streams it out one word per cycle.
// Define MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN to add a shadow bank for gapless back-to-back vectors.
module multiple_add_serializer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_ADDERS = 64,
  localparam int IDX_W      = (NUM_ADDERS > 1) ? $clog2(NUM_ADDERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in [NUM_ADDERS],
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ADDERS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   bank_q [NUM_ADDERS];
  logic                    accept, xfer, xfer_last;
  logic                    load_active;
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_ADDERS];
  logic                    shadow_vld_q, shadow_vld_d;
  logic                    load_shadow, copy_shadow;
`endif

  assign valid_out = (state_q == SEND);
  assign out       = bank_q[idx_q];
  assign out_index = idx_q;
  assign out_last  = valid_out && (idx_q == LAST_IDX);
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
  assign in_ready  = !rst && !shadow_vld_q;
`else
  assign in_ready  = !rst && (state_q == IDLE);
`endif

  assign accept    = valid_in && in_ready;
  assign xfer      = valid_out && ready_in;
  assign xfer_last = xfer && (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_active = 1'b0;
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
    shadow_vld_d = shadow_vld_q;
    load_shadow  = 1'b0;
    copy_shadow  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SEND;
          idx_d       = '0;
          load_active = 1'b1;
        end
      end
      SEND: begin
        if (xfer_last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
        end
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
        // accept is impossible while the shadow is full, so these cases are exclusive
        if (xfer_last && shadow_vld_q) begin
          state_d      = SEND;
          copy_shadow  = 1'b1;
          shadow_vld_d = 1'b0;
        end else if (accept && xfer_last) begin
          state_d     = SEND;
          load_active = 1'b1;
        end else if (accept) begin
          load_shadow  = 1'b1;
          shadow_vld_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
      shadow_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
      shadow_vld_q <= shadow_vld_d;
`endif
    end
  end

  // Data banks carry no reset; valid_out gates their meaning.
  always_ff @(posedge clk) begin
    if (load_active) begin
      bank_q <= in;
    end
`ifdef MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN
    else if (copy_shadow) begin
      bank_q <= shadow_q;
    end
    if (load_shadow) begin
      shadow_q <= in;
    end
`endif
  end

endmodule

// File: doc/multiple_add_serializer.md
Name: multiple_add_serializer

Overview:
- Consumer for the multiple_add pipeline output: captures one NUM_ADDERS-word result vector on a valid/ready handshake and streams it out one word per cycle.
- Downstream side is a valid/ready stream with back-pressure.
- Sits between the parallel adder bank and a narrow sink (FIFO, host channel).
- Only control state is reset; data buffers are unreset.

Parameters:
- DATA_WIDTH, 32, bit width of each result word.
- NUM_ADDERS, 64, number of words per input vector (>= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset. Synchronous and active-high.
- in  input  DATA_WIDTH x NUM_ADDERS (unpacked array)  result vector from the adder pipeline.
- valid_in  input  1  in holds a valid vector.
- in_ready  output  1  block can accept a vector this cycle.
- out  output  DATA_WIDTH  current serialized word.
- out_index  output  IDX_W = max(1, $clog2(NUM_ADDERS))  position of out within its vector.
- out_last  output  1  out is word NUM_ADDERS-1 of its vector.
- valid_out  output  1  out, out_index and out_last are valid.
- ready_in  input  1  downstream accepts the word this cycle.

Behaviour:
- Handshake terms:
  - Accept = valid_in && in_ready.
  - Transfer = valid_out && ready_in.
- FSM states and transitions:
  - IDLE -> SEND on accept: latch all NUM_ADDERS words into the active bank, set idx = 0.
  - SEND: valid_out = 1, out = bank[idx], out_index = idx, out_last = (idx == NUM_ADDERS-1).
  - SEND, on a transfer that is not the last word: idx++.
  - SEND, on the last-word transfer: go to IDLE and set idx = 0.
- in_ready = (state == IDLE) && !rst. This is combinational from registered state; it is independent of valid_in.
- Latency: first word is valid on the cycle after accept.
  - Throughput with ready_in held high: NUM_ADDERS words per NUM_ADDERS+1 cycles (one idle gap per vector).
- Back-pressure:
  - While valid_out && !ready_in, out, out_index and out_last hold stable.
  - valid_out never deasserts without a transfer.
- Input stability: in may change after the accept cycle; the block owns its captured copy.
- NUM_ADDERS == 1: out_last = 1 on every word; every transfer returns to IDLE.
- valid_in while in_ready = 0: ignored. The upstream producer must hold or drop the vector; no capture occurs.
- Reset values, and behaviour on rst asserted at any point including mid-vector:
  - state = IDLE, idx = 0.
  - valid_out = 0, out_last = 0, out_index = 0.
  - The partially sent vector is discarded.
  - in_ready = 0 during the reset cycle and 1 on the first cycle after rst deasserts.
  - out is don't-care whenever valid_out = 0.
- Out-of-range idx is unreachable; the counter wraps to 0 only via the last-word transfer.

Optional Feature:
- Macro: MULTIPLE_ADD_SERIALIZER_DOUBLE_BUFFER_EN.
- Defined: adds a shadow bank and a shadow_valid flag.
  - in_ready = !shadow_valid (plus !rst).
  - Accept in IDLE loads the active bank.
  - Accept in SEND loads the shadow bank and sets shadow_valid.
  - Accept on the same cycle as the last-word transfer with the shadow empty loads the active bank directly, stays in SEND, idx = 0.
  - Last-word transfer with shadow_valid = 1: copy shadow to active, clear shadow_valid, idx = 0, stay in SEND.
  - Result: gapless output, NUM_ADDERS words per NUM_ADDERS cycles under continuous traffic.
  - Reset also clears shadow_valid.
- Undefined: single-bank behaviour as specified above.

Test Plan:
- Single vector, ready_in = 1:
  - Stimulus: DATA_WIDTH = 32, NUM_ADDERS = 4, in = {10,11,12,13} accepted at cycle 0.
  - Response: out = 10,11,12,13 on cycles 1–4 with out_index 0–3 and out_last only at 13; in_ready = 0 on cycles 1–4 and 1 on cycle 5.
- Back-pressure:
  - Stimulus: same vector, ready_in = 0 on cycles 2–4.
  - Response: out = 11, out_index = 1 held for cycles 2–4; the sequence resumes with 12 on cycle 6; no word is lost or duplicated.
- Ignored input:
  - Stimulus: valid_in = 1 with in = {99,99,99,99} during SEND (macro undefined).
  - Response: the current vector completes unchanged; 99 is never output.
- Reset mid-vector:
  - Stimulus: rst pulsed for 1 cycle after word 1 transfers.
  - Response: valid_out = 0 the next cycle, in_ready = 1 the cycle after; a new vector {0,1,2,3} streams from index 0.
- NUM_ADDERS = 1:
  - Stimulus: three back-to-back vectors {5},{6},{7} with ready_in = 1.
  - Response: each word has out_last = 1 and out_index = 0; one idle cycle between words.
- Macro defined:
  - Stimulus: two vectors {1,2,3,4} and {5,6,7,8} offered back-to-back, ready_in = 1.
  - Response: out = 1..8 on 8 consecutive cycles with no gap; in_ready = 0 only while the shadow bank is full.
